// File: rtl/nibble_serial_addsub.sv
// Nibble-serial 16-bit add/subtract: one NIBBLE per clock, LSB first; done pulses the cycle after edge k+WIDTH/NIBBLE.
// No backpressure: start is taken only when not busy, and outputs hold until the next accepted operation.
// Optional macro ADDSUB_CARRY_IN_EN adds a cin port that sets the initial carry (add-with-carry / subtract-with-borrow).
module nibble_serial_addsub #(
    parameter int WIDTH  = 16,
    parameter int NIBBLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef ADDSUB_CARRY_IN_EN
    input  logic             cin,
`endif
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int NNIB = WIDTH / NIBBLE;
    localparam int CW   = (NNIB > 1) ? $clog2(NNIB) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                    r_state;
    logic [WIDTH-1:0]          r_a;
    logic [WIDTH-1:0]          r_b;
    logic [WIDTH-NIBBLE-1:0]   r_acc;
    logic                      r_carry;
    logic [CW-1:0]             r_cnt;
    logic                      r_busy;
    logic                      r_done;
    logic [WIDTH-1:0]          r_result;
    logic                      r_cout;
    logic                      r_overflow;
    logic                      r_zero;

    logic [NIBBLE-1:0]         w_p;
    logic [NIBBLE-1:0]         w_g;
    logic [NIBBLE:0]           w_c;
    logic [NIBBLE-1:0]         w_sum;
    logic [WIDTH-1:0]          w_full;
    logic                      w_carry0;
    logic                      w_accept;

    always_comb begin
        w_p    = r_a[NIBBLE-1:0] ^ r_b[NIBBLE-1:0];
        w_g    = r_a[NIBBLE-1:0] & r_b[NIBBLE-1:0];
        w_c    = '0;
        w_c[0] = r_carry;
        for (int j = 0; j < NIBBLE; j++) begin
            w_c[j+1] = w_g[j] | (w_p[j] & w_c[j]);
        end
        w_sum  = w_p ^ w_c[NIBBLE-1:0];
        w_full = {w_sum, r_acc};
    end

`ifdef ADDSUB_CARRY_IN_EN
    assign w_carry0 = cin;
`else
    assign w_carry0 = op;
`endif

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        // Subtract is a + ~b + 1; the +1 comes in through the initial carry.
                        r_a     <= a;
                        r_b     <= op ? ~b : b;
                        r_carry <= w_carry0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> NIBBLE;
                    r_b     <= r_b >> NIBBLE;
                    r_acc   <= w_full[WIDTH-1:NIBBLE];
                    r_carry <= w_c[NIBBLE];
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CW'(NNIB - 1)) begin
                        r_result   <= w_full;
                        r_cout     <= w_c[NIBBLE];
                        r_overflow <= w_c[NIBBLE] ^ w_c[NIBBLE-1];
                        r_zero     <= (w_full == '0);
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_overflow;
    assign zero     = r_zero;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Bench for nibble_serial_addsub: arithmetic model compared every cycle plus directed literal checks.
module tb_nibble_serial_addsub;
    localparam int NN = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
`ifdef ADDSUB_CARRY_IN_EN
    logic        cin;
`endif
    logic        busy, done, cout, overflow, zero;
    logic [15:0] result;

    int errors = 0;
    int checks = 0;

    nibble_serial_addsub dut (
        .clk(clk), .rst_n(rst_n),
`ifdef ADDSUB_CARRY_IN_EN
        .cin(cin),
`endif
        .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .cout(cout), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    // Transaction-level model: computes the answer by plain arithmetic at acceptance,
    // then releases it NN edges later.
    logic        m_valid = 1'b0;
    int          m_left;
    logic        m_busy, m_done, m_cout, m_ovf, m_zero;
    logic [15:0] m_res;
    logic [16:0] p_sum;
    logic        p_ovf;

    always @(posedge clk) begin
        logic [15:0] bb;
        logic        c0;
        if (!rst_n) begin
            m_valid = 1'b1; m_left = 0; m_busy = 0; m_done = 0;
            m_res = 0; m_cout = 0; m_ovf = 0; m_zero = 0;
        end else if (m_valid) begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    {m_cout, m_res} = p_sum;
                    m_ovf  = p_ovf;
                    m_zero = (p_sum[15:0] == 16'h0);
                    m_busy = 0;
                    m_done = 1;
                end
            end else begin
                m_done = 0;
                if (start) begin
                    bb = op ? ~b : b;
`ifdef ADDSUB_CARRY_IN_EN
                    c0 = cin;
`else
                    c0 = op;
`endif
                    p_sum  = {1'b0, a} + {1'b0, bb} + {16'h0, c0};
                    p_ovf  = (a[15] == bb[15]) && (p_sum[15] != a[15]);
                    m_left = NN;
                    m_busy = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if ({busy, done, cout, overflow, zero, result} !== {m_busy, m_done, m_cout, m_ovf, m_zero, m_res}) begin
                errors++;
                $display("FAIL model t=%0t: busy/done/cout/ovf/zero/result got %b%b%b%b%b %h, required %b%b%b%b%b %h",
                         $time, busy, done, cout, overflow, zero, result,
                         m_busy, m_done, m_cout, m_ovf, m_zero, m_res);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Drives start for exactly one edge, then scrambles inputs to show they are not re-sampled.
    task automatic launch(input logic o, input logic [15:0] x, input logic [15:0] y, input logic ci);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
`ifdef ADDSUB_CARRY_IN_EN
        cin = ci;
`endif
        @(negedge clk);
        start = 1'b0; op = ~o; a = 16'hDEAD; b = 16'hBEEF;
`ifdef ADDSUB_CARRY_IN_EN
        cin = ~ci;
`endif
    endtask

    task automatic wait_done(output int n, output int nbusy);
        n = 0; nbusy = 0;
        while (done !== 1'b1 && n < 20) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            errors++;
            $display("FAIL timeout: done not seen within %0d cycles", n);
        end
    endtask

    task automatic chk_out(input string name, input logic [15:0] r, input logic c, input logic v, input logic z);
        chk({name, ".result"}, {16'h0, result}, {16'h0, r});
        chk({name, ".cout"}, {31'h0, cout}, {31'h0, c});
        chk({name, ".ovf"}, {31'h0, overflow}, {31'h0, v});
        chk({name, ".zero"}, {31'h0, zero}, {31'h0, z});
        chk({name, ".model"}, {m_res, 13'h0, m_cout, m_ovf, m_zero}, {r, 13'h0, c, v, z});
    endtask

    initial begin
        int n, nb;
        rst_n = 1'b0; start = 1'b0; op = 1'b0; a = 16'h0; b = 16'h0;
`ifdef ADDSUB_CARRY_IN_EN
        cin = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset", {26'h0, busy, done, cout, overflow, zero, |result}, 32'h0);
        rst_n = 1'b1;

        launch(1'b0, 16'h1234, 16'h4321, 1'b0);
        wait_done(n, nb);
        chk("add1.latency", n, 4);
        chk("add1.busy_cycles", nb, 4);
        chk_out("add1", 16'h5555, 1'b0, 1'b0, 1'b0);

        launch(1'b0, 16'hFFFF, 16'h0001, 1'b0);
        wait_done(n, nb);
        chk_out("add_wrap", 16'h0000, 1'b1, 1'b0, 1'b1);

        launch(1'b1, 16'h8000, 16'h0001, 1'b1);
        wait_done(n, nb);
        chk_out("sub_ovf", 16'h7FFF, 1'b1, 1'b1, 1'b0);

        launch(1'b1, 16'h0003, 16'h0005, 1'b1);
        wait_done(n, nb);
        chk_out("sub_neg", 16'hFFFE, 1'b0, 1'b0, 1'b0);

        launch(1'b0, 16'h7FFF, 16'h0001, 1'b0);
        wait_done(n, nb);
        chk_out("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b0);
        // Back-to-back: start asserted during the DONE cycle.
        start = 1'b1; op = 1'b1; a = 16'h0005; b = 16'h0005;
`ifdef ADDSUB_CARRY_IN_EN
        cin = 1'b1;
`endif
        n = 0;
        @(negedge clk); n++;
        start = 1'b0; a = 16'h1357; b = 16'h2468; op = 1'b0;
        chk("b2b.done_drops", {31'h0, done}, 32'h0);
        chk("b2b.held", {16'h0, result}, 32'h8000);
        while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("b2b.spacing", n, 5);
        chk_out("sub_zero", 16'h0000, 1'b1, 1'b0, 1'b1);

        launch(1'b0, 16'h1111, 16'h2222, 1'b0);
        start = 1'b1; op = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, nb);
        chk("ignore.latency", n, 3);
        chk_out("ignore", 16'h3333, 1'b0, 1'b0, 1'b0);

        launch(1'b0, 16'hAAAA, 16'h1111, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort.outs", {26'h0, busy, done, cout, overflow, zero, |result}, 32'h0);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        chk("abort.no_done", n, 0);

        launch(1'b0, 16'h0F0F, 16'h00F1, 1'b0);
        wait_done(n, nb);
        chk_out("after_abort", 16'h1000, 1'b0, 1'b0, 1'b0);

`ifdef ADDSUB_CARRY_IN_EN
        launch(1'b0, 16'h00FF, 16'h0000, 1'b1);
        wait_done(n, nb);
        chk_out("adc", 16'h0100, 1'b0, 1'b0, 1'b0);
        launch(1'b1, 16'h0010, 16'h0001, 1'b0);
        wait_done(n, nb);
        chk_out("sbb", 16'h000E, 1'b1, 1'b0, 1'b0);
`endif

        // Idle with outputs held.
        repeat (3) @(negedge clk);
        chk("hold", {16'h0, result}, {16'h0, m_res});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
